// File: rtl/norm_shifter.sv
// Iterative normalizer: shifts the operand left one bit per clock until its
// leading zeros (logical) or redundant sign bits (arithmetic) are removed.
module norm_shifter #(
  parameter int WIDTH = 16,
  parameter int CNTW  = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             mode,
  input  logic [WIDTH-1:0] src,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] dst,
  output logic [CNTW-1:0]  shamt,
  output logic             zero
);

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } state_t;

  state_t            state, state_n;
  logic [WIDTH-1:0]  wreg, wreg_n;
  logic [CNTW-1:0]   cnt, cnt_n;
  logic              md, md_n;
  logic [WIDTH-1:0]  dst_n;
  logic [CNTW-1:0]   shamt_n;
  logic              zero_n;
  logic              norm;
  logic              cnt_max;

  // Arithmetic mode is normalized once the top two bits differ.
  always_comb begin
    norm    = md ? (wreg[WIDTH-1] ^ wreg[WIDTH-2]) : wreg[WIDTH-1];
    cnt_max = (cnt == CNTW'(WIDTH - 1));
  end

  always_comb begin
    state_n = state;
    wreg_n  = wreg;
    cnt_n   = cnt;
    md_n    = md;
    dst_n   = dst;
    shamt_n = shamt;
    zero_n  = zero;
    unique case (state)
      IDLE: begin
        if (start) begin
          wreg_n  = src;
          md_n    = mode;
          cnt_n   = '0;
          state_n = SHIFT;
        end
      end
      SHIFT: begin
        if (wreg == '0) begin
          dst_n   = '0;
          shamt_n = '0;
          zero_n  = 1'b1;
          state_n = DONE;
        end else if (norm || cnt_max) begin
          dst_n   = wreg;
          shamt_n = cnt;
          zero_n  = 1'b0;
          state_n = DONE;
        end else begin
          wreg_n = {wreg[WIDTH-2:0], 1'b0};
          cnt_n  = cnt + CNTW'(1);
        end
      end
      DONE: begin
        state_n = IDLE;
      end
      default: begin
        state_n = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      wreg  <= '0;
      cnt   <= '0;
      md    <= 1'b0;
      dst   <= '0;
      shamt <= '0;
      zero  <= 1'b0;
    end else begin
      state <= state_n;
      wreg  <= wreg_n;
      cnt   <= cnt_n;
      md    <= md_n;
      dst   <= dst_n;
      shamt <= shamt_n;
      zero  <= zero_n;
    end
  end

  always_comb begin
    busy = (state == SHIFT);
    done = (state == DONE);
  end

endmodule
